// File: rtl/dplbuf_arb.sv
// dplbuf_arb: DPLBUF request/grant arbiter that collects returned bursts into a show-ahead FIFO for the DMA writer.
// Define DPLBUF_ARB_STATS_EN to build the burst/timeout statistics counters; otherwise they read as zero.
module dplbuf_arb #(
    parameter int PORTS      = 12,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int HOLDOFF    = 4,
    parameter int TIMEOUT    = 256,
    parameter int PW         = $clog2(PORTS)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [PORTS-1:0] iDPLBUF_REQ,
    input  logic [PORTS-1:0] iDPLBUF_DATA_V,
    input  logic [255:0]     iDPLBUF_DATA,
    input  logic             iDMA_RDY,
    output logic [PORTS-1:0] oDPLBUF_GNT,
    output logic             oDMA_VLD,
    output logic [255:0]     oDMA_DATA,
    output logic [PW-1:0]    oDMA_PORT,
    output logic             oDMA_SOP,
    output logic             oDMA_EOP,
    output logic [1:0]       oERR,
    output logic [31:0]      oSTAT_BURSTS,
    output logic [15:0]      oSTAT_TMO
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int EW = PW + 2 + 256;

    typedef enum logic [1:0] {IDLE, GNT, XFER, HOLD} state_t;
    state_t state, nextState;

    logic [PW-1:0]    rr, sel, pick;
    logic             found, hasRoom, beatOk, lastBeat, tmo, rd, wr, errData;
    logic [CW-1:0]    beatCnt;
    logic [TW-1:0]    timer;
    logic [HW-1:0]    holdCnt;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic [PORTS-1:0] selHot;

    assign selHot      = PORTS'(1) << sel;
    assign oDPLBUF_GNT = (state == GNT) ? selHot : '0;
    assign hasRoom     = count <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
    assign beatOk      = (state == XFER) && (iDPLBUF_DATA_V == selHot);
    assign lastBeat    = beatOk && (beatCnt == CW'(BURST_LEN - 1));
    assign tmo         = (state == XFER) && !lastBeat && (timer == TW'(TIMEOUT - 1));
    assign rd          = oDMA_VLD && iDMA_RDY;
    assign wr          = beatOk && ((count != (AW+1)'(FIFO_DEPTH)) || rd);
    // Stray, multi-hot, out-of-window and overflowing beats are all dropped here
    assign errData     = (|iDPLBUF_DATA_V) && !wr;
    assign oDMA_VLD    = count != '0;
    assign {oDMA_PORT, oDMA_SOP, oDMA_EOP, oDMA_DATA} = oDMA_VLD ? mem[rdPtr] : '0;

    // Lowest offset from the RR pointer wins: scan downward so the last hit is the nearest
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (iDPLBUF_REQ[(int'(rr) + i) % PORTS]) begin
                pick  = PW'((int'(rr) + i) % PORTS);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (found && hasRoom) ? GNT : IDLE;
            GNT:     nextState = XFER;
            XFER:    nextState = (lastBeat || tmo) ? HOLD : XFER;
            HOLD:    nextState = (holdCnt == HW'(HOLDOFF - 1)) ? IDLE : HOLD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= nextState;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rr      <= '0;
            sel     <= '0;
            beatCnt <= '0;
            timer   <= '0;
            holdCnt <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            oERR    <= '0;
        end else begin
            if (state == IDLE) sel <= pick;
            if (state == GNT) begin
                rr      <= (sel == PW'(PORTS - 1)) ? '0 : sel + PW'(1);
                beatCnt <= '0;
                timer   <= '0;
            end
            if (state == XFER) timer <= timer + TW'(1);
            if (beatOk) beatCnt <= beatCnt + CW'(1);
            holdCnt <= (state == HOLD) ? holdCnt + HW'(1) : '0;
            if (wr) wrPtr <= wrPtr + AW'(1);
            if (rd) rdPtr <= rdPtr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
            if (errData) oERR[0] <= 1'b1;
            if (tmo) oERR[1] <= 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr) mem[wrPtr] <= {sel, beatCnt == CW'(0), lastBeat, iDPLBUF_DATA};
    end

`ifdef DPLBUF_ARB_STATS_EN
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSTAT_BURSTS <= '0;
            oSTAT_TMO    <= '0;
        end else begin
            if (wr && lastBeat) oSTAT_BURSTS <= oSTAT_BURSTS + 32'd1;
            if (tmo && oSTAT_TMO != 16'hFFFF) oSTAT_TMO <= oSTAT_TMO + 16'd1;
        end
    end
`else
    assign oSTAT_BURSTS = '0;
    assign oSTAT_TMO    = '0;
`endif
endmodule
